// File: rtl/proc_sequencer.sv
// Program sequencer for simple8BitProcessor: host-loaded program RAM, free-run or
// single-step issue onto func/dataIn, and capture of store results from dataOut.
module proc_sequencer #(
    parameter int          DEPTH    = 16,
    parameter int          ADDR_W   = 4,
    parameter logic [8:0]  NOP_FUNC = 9'b001_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [17:0]       prog_wdata,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              abort,
    input  logic [7:0]        proc_data_out,
    output logic [8:0]        proc_func,
    output logic [7:0]        proc_data_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        result_data,
    output logic              result_valid,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, DRAIN} state_t;

    state_t      state;
    logic [17:0] ram [DEPTH];
    logic [17:0] word;
    logic        terminal;
    logic        issue;
    logic        store_issued;  // store is on proc_func this cycle
    logic        store_exec;    // processor updated dataOut at the last edge

    assign word     = ram[pc];
    assign terminal = word[17] || (pc == ADDR_W'(DEPTH - 1));
    assign issue    = (state == RUN) || ((state == STEP_WAIT) && step);
    assign busy     = (state != IDLE);

    // RAM has no reset so a program survives a reset of the sequencer.
    always_ff @(posedge clock) begin
        if (prog_we && (state == IDLE)) begin
            ram[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            proc_func    <= NOP_FUNC;
            proc_data_in <= '0;
            done         <= 1'b0;
            pc           <= '0;
            result_data  <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            store_issued <= 1'b0;
            store_exec   <= 1'b0;
        end else begin
            err          <= busy && (prog_we || start);
            proc_func    <= NOP_FUNC;
            proc_data_in <= '0;
            store_issued <= 1'b0;

            if (busy && abort) begin
                // Flush in-flight stores so nothing is reported after an abort.
                state        <= IDLE;
                done         <= 1'b0;
                store_exec   <= 1'b0;
                result_valid <= 1'b0;
            end else begin
                store_exec   <= store_issued;
                result_valid <= store_exec;
                if (store_exec) begin
                    result_data <= proc_data_out;
                end

                if (issue) begin
                    proc_func    <= word[16:8];
                    proc_data_in <= word[7:0];
                    store_issued <= (word[16:14] == 3'b111);
                    pc           <= pc + ADDR_W'(1);
                    if (terminal) begin
                        state <= DRAIN;
                    end
                end

                case (state)
                    IDLE: begin
                        if (start) begin
                            pc    <= '0;
                            done  <= 1'b0;
                            state <= step_mode ? STEP_WAIT : RUN;
                        end
                    end
                    DRAIN: begin
                        // A store issued at the previous edge still has to be captured.
                        if (!store_issued) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: a small processor model drives dataOut, a transaction-level
// model predicts every output each cycle, and directed runs pin key values.
module tb_proc_sequencer;

    localparam int         DEPTH = 16;
    localparam int         AW    = 4;
    localparam logic [8:0] NOP   = 9'b001_000_000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [17:0]   prog_wdata = '0;
    logic          start = 1'b0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    proc_data_out;
    logic [8:0]    proc_func;
    logic [7:0]    proc_data_in;
    logic          busy, done, result_valid, err;
    logic [AW-1:0] pc;
    logic [7:0]    result_data;

    int checks = 0;
    int failures = 0;
    int rv_total = 0;

    proc_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .NOP_FUNC(NOP)) dut (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .step_mode(step_mode), .step(step),
        .abort(abort), .proc_data_out(proc_data_out), .proc_func(proc_func),
        .proc_data_in(proc_data_in), .busy(busy), .done(done), .pc(pc),
        .result_data(result_data), .result_valid(result_valid), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Processor stand-in: executes whatever func is presented at each edge.
    logic [7:0] regs [8];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
            proc_data_out <= 8'd0;
        end else begin
            case (proc_func[8:6])
                3'b000: regs[proc_func[5:3]] <= proc_data_in;
                3'b001: regs[proc_func[5:3]] <= regs[proc_func[2:0]];
                3'b010: regs[proc_func[5:3]] <= regs[proc_func[5:3]] + regs[proc_func[2:0]];
                3'b011: regs[proc_func[5:3]] <= regs[proc_func[5:3]] - regs[proc_func[2:0]];
                3'b100: regs[proc_func[5:3]] <= regs[proc_func[5:3]] & regs[proc_func[2:0]];
                3'b101: regs[proc_func[5:3]] <= regs[proc_func[5:3]] | regs[proc_func[2:0]];
                3'b110: regs[proc_func[5:3]] <= regs[proc_func[5:3]] ^ regs[proc_func[2:0]];
                default: proc_data_out <= regs[proc_func[2:0]];
            endcase
        end
    end

    // Sequencer model: program image, run bookkeeping, and due-times of store captures.
    logic [17:0] m_ram [DEPTH];
    logic [17:0] m_word;
    bit          model_ok = 0;
    bit          m_busy, m_done, m_step, m_issuing;
    int          m_pc, cyc;
    int          due_q[$];
    logic [8:0]  exp_func;
    logic [7:0]  exp_din, exp_rd;
    logic        exp_rv, exp_err;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            model_ok = 1; m_busy = 0; m_done = 0; m_issuing = 0; m_pc = 0;
            exp_func = NOP; exp_din = 0; exp_rv = 0; exp_rd = 0; exp_err = 0;
            due_q.delete();
        end else begin
            exp_err  = m_busy && (prog_we || start);
            exp_func = NOP; exp_din = 0; exp_rv = 0;
            if (m_busy && abort) begin
                m_busy = 0; m_done = 0; m_issuing = 0;
                due_q.delete();
            end else begin
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    exp_rv = 1; exp_rd = proc_data_out;
                    void'(due_q.pop_front());
                end
                if (!m_busy) begin
                    if (prog_we) m_ram[prog_addr] = prog_wdata;
                    if (start) begin
                        m_busy = 1; m_done = 0; m_step = step_mode; m_pc = 0; m_issuing = 1;
                    end
                end else if (m_issuing) begin
                    if (!m_step || step) begin
                        m_word   = m_ram[m_pc];
                        exp_func = m_word[16:8];
                        exp_din  = m_word[7:0];
                        if (m_word[16:14] == 3'b111) due_q.push_back(cyc + 2);
                        m_issuing = !(m_word[17] || m_pc == DEPTH - 1);
                        m_pc = (m_pc + 1) % DEPTH;
                    end
                end else if (due_q.size() == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            check("proc_func", 32'(proc_func), 32'(exp_func));
            check("proc_data_in", 32'(proc_data_in), 32'(exp_din));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("pc", 32'(pc), 32'(m_pc));
            check("result_valid", 32'(result_valid), 32'(exp_rv));
            check("result_data", 32'(result_data), 32'(exp_rd));
            check("err", 32'(err), 32'(exp_err));
        end
        if (result_valid) rv_total++;
    end

    // Driver tasks: inputs change just after a falling edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic load_word(input int a, input logic [17:0] w);
        prog_we = 1; prog_addr = AW'(a); prog_wdata = w;
        tick();
        prog_we = 0;
    endtask

    task automatic pulse_start(input logic mode);
        start = 1; step_mode = mode;
        tick();
        start = 0; step_mode = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    logic [17:0] prog [5];
    int n, base;

    initial begin
        prog[0] = {1'b0, 9'b000_001_000, 8'd10};
        prog[1] = {1'b0, 9'b000_000_000, 8'd5};
        prog[2] = {1'b0, 9'b110_000_001, 8'd0};
        prog[3] = {1'b0, 9'b001_111_000, 8'd0};
        prog[4] = {1'b1, 9'b111_111_000, 8'd0};

        tick(3);
        reset = 0;
        check("reset_func", 32'(proc_func), 32'(NOP));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pc", 32'(pc), 32'd0);

        // Free run
        for (int i = 0; i < 5; i++) load_word(i, prog[i]);
        base = rv_total;
        pulse_start(1'b0);
        wait_done(n);
        check("free_done_latency", 32'(n), 32'd7);
        check("free_result", 32'(result_data), 32'd15);
        tick(2);
        check("free_rv_count", 32'(rv_total - base), 32'd1);
        check("free_busy", 32'(busy), 32'd0);

        // Single step, one pulse every 4 cycles
        base = rv_total;
        pulse_start(1'b1);
        for (int s = 0; s < 5; s++) begin
            tick(3);
            step = 1;
            tick();
            step = 0;
        end
        wait_done(n);
        check("step_drain", 32'(n), 32'd2);
        check("step_pc", 32'(pc), 32'd5);
        check("step_result", 32'(result_data), 32'd15);
        tick(2);
        check("step_rv_count", 32'(rv_total - base), 32'd1);

        // Full RAM without a last bit
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0) load_word(i, {1'b0, 9'b000_010_000, 8'(i)});
            else            load_word(i, {1'b0, 9'b010_011_010, 8'd0});
        end
        pulse_start(1'b0);
        wait_done(n);
        check("full_latency", 32'(n), 32'd17);
        check("full_pc_wrap", 32'(pc), 32'd0);

        // Abort while the store is on proc_func
        for (int i = 0; i < 5; i++) load_word(i, prog[i]);
        pulse_start(1'b0);
        n = 0;
        while (proc_func != 9'b111_111_000 && n < 20) begin
            tick();
            n++;
        end
        check("abort_store_seen", 32'(proc_func), 32'(9'b111_111_000));
        base = rv_total;
        abort = 1;
        tick();
        abort = 0;
        check("abort_func", 32'(proc_func), 32'(NOP));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        tick(4);
        check("abort_rv_count", 32'(rv_total - base), 32'd0);

        // Rejected write and start while busy
        pulse_start(1'b0);
        tick();
        prog_we = 1; prog_addr = 4'd4; prog_wdata = 18'h00000;
        tick();
        prog_we = 0;
        check("err_on_write", 32'(err), 32'd1);
        start = 1;
        tick();
        start = 0;
        check("err_on_start", 32'(err), 32'd1);
        wait_done(n);
        tick(2);
        base = rv_total;
        pulse_start(1'b0);
        wait_done(n);
        check("rerun_latency", 32'(n), 32'd7);
        check("rerun_result", 32'(result_data), 32'd15);
        tick(2);
        check("rerun_rv_count", 32'(rv_total - base), 32'd1);

        // Reset in the middle of a run, then restart without reloading
        pulse_start(1'b0);
        tick(3);
        reset = 1;
        tick();
        reset = 0;
        check("midreset_func", 32'(proc_func), 32'(NOP));
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_pc", 32'(pc), 32'd0);
        check("midreset_rd", 32'(result_data), 32'd0);
        base = rv_total;
        pulse_start(1'b0);
        wait_done(n);
        check("restart_result", 32'(result_data), 32'd15);
        tick(2);
        check("restart_rv_count", 32'(rv_total - base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
